// File: rtl/router_sync_ctrl_pkg.sv
// Shared types and constants for the router destination controller.
// Destination address 2'b11 selects no FIFO.
package router_pkg;

  localparam int unsigned NUM_PORTS       = 3;
  localparam int unsigned TIMEOUT_DEFAULT = 30;
  localparam int unsigned ADDR_W          = 2;

  typedef logic [ADDR_W-1:0]    addr_t;
  typedef logic [NUM_PORTS-1:0] port_vec_t;

  localparam addr_t ADDR_INVALID = 2'b11;

  typedef enum logic [ADDR_W-1:0] {
    DEST_0    = 2'b00,
    DEST_1    = 2'b01,
    DEST_2    = 2'b10,
    DEST_NONE = ADDR_INVALID
  } dest_e;

  // One-hot FIFO select for an address; the invalid address selects nothing.
  function automatic port_vec_t dest_onehot(addr_t a);
    port_vec_t v;
    v = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (a == addr_t'(i)) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/router_sync_ctrl_if.sv
// FSM-side handshake between the router FSM (master) and the
// destination controller (slave).
interface router_sync_ctrl_if;

  logic                        detect_add;
  router_pkg::addr_t           data_in;
  logic                        write_enb_reg;
  router_pkg::port_vec_t       write_enb;
  logic                        fifo_full;

  modport master (
    output detect_add,
    output data_in,
    output write_enb_reg,
    input  write_enb,
    input  fifo_full
  );

  modport slave (
    input  detect_add,
    input  data_in,
    input  write_enb_reg,
    output write_enb,
    output fifo_full
  );

endinterface

// File: rtl/router_sync_ctrl_timeout_ctr.sv
// Per-port drain watchdog: pulses soft_reset for one cycle after TIMEOUT
// consecutive cycles of valid data that nobody reads.
module router_timeout_ctr #(
  parameter int unsigned TIMEOUT = 30,
  parameter int unsigned CNT_W   = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic vld,
  input  logic rd,
  output logic soft_reset
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             soft_reset_q, soft_reset_d;
  logic             idle;

  // The pulse cycle itself is not idle, so the count sits at 0 while it is high.
  assign idle = vld & ~rd & ~soft_reset_q;

  always_comb begin
    cnt_d        = '0;
    soft_reset_d = 1'b0;
    if (idle) begin
      if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
        soft_reset_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q        <= '0;
      soft_reset_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      soft_reset_q <= soft_reset_d;
    end
  end

  assign soft_reset = soft_reset_q;

endmodule

// File: rtl/router_sync_ctrl.sv
// Router destination controller: latches the header address, steers the
// FSM write strobe and full flag, and watches each output for stalls.
module router_sync_ctrl
  import router_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W   = 5
) (
  input  logic                clock,
  input  logic                reset,
  router_sync_ctrl_if.slave   fsm,
  input  logic                read_enb_0,
  input  logic                read_enb_1,
  input  logic                read_enb_2,
  input  logic                empty_0,
  input  logic                empty_1,
  input  logic                empty_2,
  input  logic                full_0,
  input  logic                full_1,
  input  logic                full_2,
  output logic                vld_out_0,
  output logic                vld_out_1,
  output logic                vld_out_2,
  output logic                soft_reset_0,
  output logic                soft_reset_1,
  output logic                soft_reset_2
);

  addr_t     addr_q, addr_d;
  port_vec_t rd_vec, empty_vec, full_vec, vld_vec, sr_vec;

  assign rd_vec    = {read_enb_2, read_enb_1, read_enb_0};
  assign empty_vec = {empty_2, empty_1, empty_0};
  assign full_vec  = {full_2, full_1, full_0};
  assign vld_vec   = ~empty_vec;

  always_comb begin
    addr_d = addr_q;
    if (fsm.detect_add) addr_d = fsm.data_in;
  end

  always_ff @(posedge clock) begin
    if (reset) addr_q <= '0;
    else       addr_q <= addr_d;
  end

  // Steering uses the registered address, so a header strobe coinciding
  // with a write still targets the previous destination.
  always_comb begin
    fsm.write_enb = '0;
    if (fsm.write_enb_reg) fsm.write_enb = dest_onehot(addr_q);
  end

  always_comb begin
    fsm.fifo_full = 1'b0;
    case (dest_e'(addr_q))
      DEST_0:  fsm.fifo_full = full_vec[0];
      DEST_1:  fsm.fifo_full = full_vec[1];
      DEST_2:  fsm.fifo_full = full_vec[2];
      default: fsm.fifo_full = 1'b0;
    endcase
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    router_timeout_ctr #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
    ) u_timeout (
      .clock      (clock),
      .reset      (reset),
      .vld        (vld_vec[g]),
      .rd         (rd_vec[g]),
      .soft_reset (sr_vec[g])
    );
  end

  assign vld_out_0    = vld_vec[0];
  assign vld_out_1    = vld_vec[1];
  assign vld_out_2    = vld_vec[2];
  assign soft_reset_0 = sr_vec[0];
  assign soft_reset_1 = sr_vec[1];
  assign soft_reset_2 = sr_vec[2];

endmodule

// File: tb/tb_router_sync_ctrl.sv
// Self-checking bench for router_sync_ctrl: directed scenarios plus a
// randomized run against a behavioural model.
module tb_router_sync_ctrl;

  localparam int TO = 30;

  logic clock;
  logic reset;
  logic [2:0] rd, empty, full;
  logic vld_out_0, vld_out_1, vld_out_2;
  logic soft_reset_0, soft_reset_1, soft_reset_2;
  logic [2:0] vld, sr;

  int checks = 0;
  int errors = 0;

  router_sync_ctrl_if bus ();

  router_sync_ctrl #(
    .TIMEOUT (TO),
    .CNT_W   (5)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .fsm          (bus),
    .read_enb_0   (rd[0]),
    .read_enb_1   (rd[1]),
    .read_enb_2   (rd[2]),
    .empty_0      (empty[0]),
    .empty_1      (empty[1]),
    .empty_2      (empty[2]),
    .full_0       (full[0]),
    .full_1       (full[1]),
    .full_2       (full[2]),
    .vld_out_0    (vld_out_0),
    .vld_out_1    (vld_out_1),
    .vld_out_2    (vld_out_2),
    .soft_reset_0 (soft_reset_0),
    .soft_reset_1 (soft_reset_1),
    .soft_reset_2 (soft_reset_2)
  );

  assign vld = {vld_out_2, vld_out_1, vld_out_0};
  assign sr  = {soft_reset_2, soft_reset_1, soft_reset_0};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model: length of each port's current unread run, and the
  // destination most recently announced by a header.
  int         m_run [3] = '{0, 0, 0};
  logic [2:0] m_sr   = 3'b000;
  logic [1:0] m_addr = 2'b00;

  always @(posedge clock) begin
    if (reset) begin
      m_run  = '{0, 0, 0};
      m_sr   = 3'b000;
      m_addr = 2'b00;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (!empty[i] && !rd[i] && !m_sr[i]) m_run[i] = m_run[i] + 1;
        else                                 m_run[i] = 0;
        if (m_run[i] >= TO) begin
          m_sr[i]  = 1'b1;
          m_run[i] = 0;
        end else begin
          m_sr[i] = 1'b0;
        end
      end
      if (bus.detect_add) m_addr = bus.data_in;
    end
  end

  function automatic logic [2:0] exp_wen(logic [1:0] a, logic w);
    logic [2:0] v;
    v = 3'b000;
    if (w && a != 2'b11) v[a] = 1'b1;
    return v;
  endfunction

  function automatic logic exp_full(logic [1:0] a, logic [2:0] f);
    if (a == 2'b11) return 1'b0;
    return f[a];
  endfunction

  task automatic idle_inputs();
    bus.detect_add    = 1'b0;
    bus.data_in       = 2'b00;
    bus.write_enb_reg = 1'b0;
    rd                = 3'b000;
    empty             = 3'b111;
    full              = 3'b000;
  endtask

  task automatic do_reset();
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset             = 1'b1;
    bus.detect_add    = 1'b1;
    bus.data_in       = 2'b11;
    bus.write_enb_reg = 1'b0;
    rd                = 3'b000;
    empty             = 3'b000;
    full              = 3'b111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      checks++;
      if (sr !== 3'b000) begin
        errors++; $display("FAIL reset_sr: got %b want 000", sr);
      end
      checks++;
      if (bus.write_enb !== 3'b000) begin
        errors++; $display("FAIL reset_wen: got %b want 000", bus.write_enb);
      end
    end
    checks++;
    if (vld !== 3'b111) begin
      errors++; $display("FAIL reset_vld: got %b want 111", vld);
    end
    checks++;
    if (bus.fifo_full !== 1'b1) begin
      errors++; $display("FAIL reset_addr_full: got %b want 1", bus.fifo_full);
    end
    full = 3'b110;
    #1;
    checks++;
    if (bus.fifo_full !== 1'b0) begin
      errors++; $display("FAIL reset_addr_full0: got %b want 0", bus.fifo_full);
    end
    reset             = 1'b0;
    bus.detect_add    = 1'b0;
    bus.write_enb_reg = 1'b1;
    empty             = 3'b111;
    #1;
    checks++;
    if (bus.write_enb !== 3'b001) begin
      errors++; $display("FAIL reset_addr_wen: got %b want 001", bus.write_enb);
    end
  endtask

  task automatic test_steer();
    do_reset();
    bus.detect_add = 1'b1;
    bus.data_in    = 2'b10;
    @(negedge clock);
    bus.detect_add    = 1'b0;
    bus.write_enb_reg = 1'b1;
    full              = 3'b100;
    #1;
    checks++;
    if (bus.write_enb !== 3'b100) begin
      errors++; $display("FAIL steer_wen: got %b want 100", bus.write_enb);
    end
    checks++;
    if (bus.fifo_full !== 1'b1) begin
      errors++; $display("FAIL steer_full: got %b want 1", bus.fifo_full);
    end
    full = 3'b011;
    #1;
    checks++;
    if (bus.fifo_full !== 1'b0) begin
      errors++; $display("FAIL steer_full_other: got %b want 0", bus.fifo_full);
    end
    bus.write_enb_reg = 1'b0;
    #1;
    checks++;
    if (bus.write_enb !== 3'b000) begin
      errors++; $display("FAIL steer_wen_off: got %b want 000", bus.write_enb);
    end
  endtask

  task automatic test_invalid_addr();
    @(negedge clock);
    bus.detect_add = 1'b1;
    bus.data_in    = 2'b11;
    @(negedge clock);
    bus.detect_add    = 1'b0;
    bus.write_enb_reg = 1'b1;
    full              = 3'b111;
    #1;
    checks++;
    if (bus.write_enb !== 3'b000) begin
      errors++; $display("FAIL invalid_wen: got %b want 000", bus.write_enb);
    end
    checks++;
    if (bus.fifo_full !== 1'b0) begin
      errors++; $display("FAIL invalid_full: got %b want 0", bus.fifo_full);
    end
  endtask

  task automatic test_same_cycle();
    @(negedge clock);
    idle_inputs();
    bus.detect_add = 1'b1;
    bus.data_in    = 2'b00;
    @(negedge clock);
    bus.detect_add    = 1'b1;
    bus.data_in       = 2'b01;
    bus.write_enb_reg = 1'b1;
    #1;
    checks++;
    if (bus.write_enb !== 3'b001) begin
      errors++; $display("FAIL same_cycle_old: got %b want 001", bus.write_enb);
    end
    @(negedge clock);
    bus.detect_add = 1'b0;
    #1;
    checks++;
    if (bus.write_enb !== 3'b010) begin
      errors++; $display("FAIL same_cycle_new: got %b want 010", bus.write_enb);
    end
  endtask

  task automatic test_timeout_pulse();
    logic want;
    do_reset();
    empty[0] = 1'b0;
    for (int k = 1; k <= 62; k++) begin
      @(negedge clock);
      want = (k == 30 || k == 61);
      checks++;
      if (sr[0] !== want) begin
        errors++; $display("FAIL timeout_pulse edge %0d: got %b want %b", k, sr[0], want);
      end
      checks++;
      if (sr[2:1] !== 2'b00) begin
        errors++; $display("FAIL timeout_other_ports edge %0d: got %b want 00", k, sr[2:1]);
      end
    end
  endtask

  task automatic test_timeout_restart();
    logic want;
    do_reset();
    empty[1] = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clock);
      checks++;
      if (sr[1] !== 1'b0) begin
        errors++; $display("FAIL restart_pre edge %0d: got %b want 0", k, sr[1]);
      end
    end
    rd[1] = 1'b1;
    @(negedge clock);
    rd[1] = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      want = (k == 30);
      checks++;
      if (sr[1] !== want) begin
        errors++; $display("FAIL restart_read edge %0d: got %b want %b", k, sr[1], want);
      end
    end
    @(negedge clock);
    for (int k = 1; k <= 24; k++) begin
      @(negedge clock);
      checks++;
      if (sr[1] !== 1'b0) begin
        errors++; $display("FAIL restart_prereset edge %0d: got %b want 0", k, sr[1]);
      end
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    checks++;
    if (sr[1] !== 1'b0) begin
      errors++; $display("FAIL restart_reset_edge: got %b want 0", sr[1]);
    end
    for (int k = 1; k <= 30; k++) begin
      @(negedge clock);
      want = (k == 30);
      checks++;
      if (sr[1] !== want) begin
        errors++; $display("FAIL restart_after_reset edge %0d: got %b want %b", k, sr[1], want);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      @(negedge clock);
      reset             = ($urandom_range(0, 299) == 0);
      bus.detect_add    = ($urandom_range(0, 7) == 0);
      bus.data_in       = 2'($urandom_range(0, 3));
      bus.write_enb_reg = 1'($urandom_range(0, 1));
      full              = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) begin
        empty[i] = ($urandom_range(0, 63) == 0);
        rd[i]    = ($urandom_range(0, 47) == 0);
      end
      #1;
      checks++;
      if (bus.write_enb !== exp_wen(m_addr, bus.write_enb_reg)) begin
        errors++; $display("FAIL rand_wen cycle %0d: got %b want %b", n, bus.write_enb, exp_wen(m_addr, bus.write_enb_reg));
      end
      checks++;
      if (bus.fifo_full !== exp_full(m_addr, full)) begin
        errors++; $display("FAIL rand_full cycle %0d: got %b want %b", n, bus.fifo_full, exp_full(m_addr, full));
      end
      checks++;
      if (vld !== ~empty) begin
        errors++; $display("FAIL rand_vld cycle %0d: got %b want %b", n, vld, ~empty);
      end
      checks++;
      if (sr !== m_sr) begin
        errors++; $display("FAIL rand_sr cycle %0d: got %b want %b", n, sr, m_sr);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    test_reset();
    test_steer();
    test_invalid_addr();
    test_same_cycle();
    test_timeout_pulse();
    test_timeout_restart();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
